reg_file_mp: RTL and testbench

Parametrised multi-port register file: the next-generation integer register file for the RISC datapath, feeding decode/execute read operands and accepting writeback results. It generalises width, depth and port counts, adds a hardwired zero register, optional same-cycle write-to-read bypass, and a sequential clear sweep that zeroes every entry after reset or on request. A `busy` flag gates the datapath during the sweep.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_clear_seq.sv | 70 +++++++
 rtl/reg_file_mp.sv | 105 ++++++++++
 tb/tb_reg_file_mp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared types and default sizes for the multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned C_DATA_W = 32;
    localparam int unsigned C_ADDR_W = 5;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rf_clear_seq.sv
// ============================================================================
// Module      : rf_clear_seq
// Description : Clear-sweep sequencer: walks every entry once, zeroing it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic              i_clr,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_clr_we
);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rstd) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A clear request always restarts the sweep from entry 0.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (i_clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                if (i_clr) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == {ADDR_W{1'b1}}) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_ptr;

endmodule : rf_clear_seq

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Parametrised multi-port register file with zero register,
//               optional write-to-read bypass and a post-reset clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = C_DATA_W,
    parameter int ADDR_W   = C_ADDR_W,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     clr,
    input  logic [NREAD*ADDR_W-1:0]  ra,
    output logic [NREAD*DATA_W-1:0]  rr,
    input  logic [NWRITE*ADDR_W-1:0] wa,
    input  logic [NWRITE*DATA_W-1:0] wr,
    input  logic [NWRITE-1:0]        wren,
    output logic                     busy
);

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [NWRITE-1:0] w_wen;

    // Storage has no reset of its own; the sweep zeroes it after every reset.
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk        (clk),
        .rstd       (rstd),
        .i_clr      (clr),
        .o_busy     (w_busy),
        .o_clr_addr (w_clr_addr),
        .o_clr_we   (w_clr_we)
    );

    assign busy = w_busy;

    // Active-low enables, qualified by idle state and zero-register discard.
    always_comb begin
        w_wen = '0;
        for (int j = 0; j < NWRITE; j++) begin
            w_wen[j] = !wren[j] && !w_busy &&
                       !((ZERO_REG != 0) && (wa[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    // Later ports are applied last, so port 1 wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rstd) begin
            if (w_clr_we) begin
                r_mem[w_clr_addr] <= '0;
            end else begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (w_wen[j]) begin
                        r_mem[wa[j*ADDR_W +: ADDR_W]] <= wr[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_read
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;

            always_comb begin
                w_addr = ra[gi*ADDR_W +: ADDR_W];
                w_data = r_mem[w_addr];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (w_wen[j] && (wa[j*ADDR_W +: ADDR_W] == w_addr)) begin
                            w_data = wr[j*DATA_W +: DATA_W];
                        end
                    end
                end
                if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_data = '0;
                end
                if (w_busy) begin
                    w_data = '0;
                end
            end

            assign rr[gi*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

endmodule : reg_file_mp

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Directed self-checking bench for reg_file_mp (bypass and
//               non-bypass instances side by side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rstd;
    logic              clr;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rr;
    logic [NR*DW-1:0]  nb_rr;
    logic [NW*AW-1:0]  wa;
    logic [NW*DW-1:0]  wr;
    logic [NW-1:0]     wren;
    logic              busy;
    logic              nb_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NREAD (NR), .NWRITE (NW),
        .ZERO_REG (1), .BYPASS (1)
    ) dut (
        .clk (clk), .rstd (rstd), .clr (clr), .ra (ra), .rr (rr),
        .wa (wa), .wr (wr), .wren (wren), .busy (busy)
    );

    // Single write port, no bypass; shares write port 0 of the main DUT.
    reg_file_mp #(
        .DATA_W (DW), .ADDR_W (AW), .NREAD (NR), .NWRITE (1),
        .ZERO_REG (1), .BYPASS (0)
    ) dut_nb (
        .clk (clk), .rstd (rstd), .clr (clr), .ra (ra), .rr (nb_rr),
        .wa (wa[AW-1:0]), .wr (wr[DW-1:0]), .wren (wren[0]), .busy (nb_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cyc;
        int err;
        rstd = 1'b1; clr = 1'b0; wren = '1; wa = '0; wr = '0; ra = '0;
        step();
        step();
        n_cmp++;
        if (busy !== 1'b1 || rr !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rr=%h, required busy=1 rr=0", busy, rr);
        end
        rstd = 1'b0;
        cyc = 0; err = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (rr !== '0 || nb_rr !== '0 || nb_busy !== busy) err++;
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles, required 32", cyc);
        end
        n_cmp++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL reset_rr_zero: %0d busy cycles with nonzero rr, required 0", err);
        end
        err = 0;
        for (int i = 0; i < 32; i++) begin
            ra = {AW'(i), AW'(i)};
            #1;
            if (rr !== '0 || nb_rr !== '0) err++;
        end
        n_cmp++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL reset_cleared: %0d entries nonzero, required 0", err);
        end
    endtask

    task automatic test_write();
        wa[AW-1:0] = 5'd5; wr[DW-1:0] = 32'hDEADBEEF; wren = 2'b10;
        ra = {5'd0, 5'd5};
        #1;
        n_cmp++;
        if (rr[DW-1:0] !== 32'hDEADBEEF || nb_rr[DW-1:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL write_same_cycle: rr0=%h nb_rr0=%h, required deadbeef/00000000",
                     rr[DW-1:0], nb_rr[DW-1:0]);
        end
        step();
        wren = 2'b11;
        #1;
        n_cmp++;
        if (rr[DW-1:0] !== 32'hDEADBEEF || nb_rr[DW-1:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_stored: rr0=%h nb_rr0=%h, required deadbeef",
                     rr[DW-1:0], nb_rr[DW-1:0]);
        end
    endtask

    task automatic test_bypass();
        wa[AW-1:0] = 5'd7; wr[DW-1:0] = 32'h12345678; wren = 2'b10;
        ra = {5'd7, 5'd5};
        #1;
        n_cmp++;
        if (rr[DW +: DW] !== 32'h12345678 || nb_rr[DW +: DW] !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_same_cycle: rr1=%h nb_rr1=%h, required 12345678/00000000",
                     rr[DW +: DW], nb_rr[DW +: DW]);
        end
        step();
        wren = 2'b11;
        #1;
        n_cmp++;
        if (nb_rr[DW +: DW] !== 32'h12345678 || rr[DW +: DW] !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_next_cycle: rr1=%h nb_rr1=%h, required 12345678",
                     rr[DW +: DW], nb_rr[DW +: DW]);
        end
    endtask

    task automatic test_zero_reg();
        wa[AW-1:0] = 5'd0; wr[DW-1:0] = 32'hFFFFFFFF; wren = 2'b10;
        ra = '0;
        #1;
        n_cmp++;
        if (rr !== '0 || nb_rr !== '0) begin
            n_fail++;
            $display("FAIL zero_same_cycle: rr=%h nb_rr=%h, required 0", rr, nb_rr);
        end
        step();
        wren = 2'b11;
        #1;
        n_cmp++;
        if (rr !== '0 || nb_rr !== '0) begin
            n_fail++;
            $display("FAIL zero_after: rr=%h nb_rr=%h, required 0", rr, nb_rr);
        end
    endtask

    task automatic test_dual_write();
        wa = {5'd9, 5'd9}; wr = {32'h00002222, 32'h00001111}; wren = 2'b00;
        ra = {5'd5, 5'd9};
        #1;
        n_cmp++;
        if (rr[DW-1:0] !== 32'h00002222) begin
            n_fail++;
            $display("FAIL dual_bypass: rr0=%h, required 00002222", rr[DW-1:0]);
        end
        step();
        wren = 2'b11;
        #1;
        n_cmp++;
        if (rr[DW-1:0] !== 32'h00002222 || nb_rr[DW-1:0] !== 32'h00001111) begin
            n_fail++;
            $display("FAIL dual_stored: rr0=%h nb_rr0=%h, required 00002222/00001111",
                     rr[DW-1:0], nb_rr[DW-1:0]);
        end
    endtask

    task automatic test_clr_restart();
        int cyc;
        clr = 1'b1;
        step();
        clr = 1'b0;
        ra = {5'd7, 5'd5};
        n_cmp++;
        if (busy !== 1'b1 || rr !== '0) begin
            n_fail++;
            $display("FAIL clr_enter: busy=%b rr=%h, required busy=1 rr=0", busy, rr);
        end
        repeat (10) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        n_cmp++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL clr_restart_len: got %0d cycles, required 32", cyc);
        end
        n_cmp++;
        if (rr !== '0) begin
            n_fail++;
            $display("FAIL clr_cleared: rr=%h, required 0", rr);
        end
    endtask

    task automatic test_busy_write_reset();
        int cyc;
        int err;
        wa[AW-1:0] = 5'd5; wr[DW-1:0] = 32'hDEADBEEF; wren = 2'b10;
        step();
        wren = 2'b11;
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (5) step();
        rstd = 1'b1;
        step();
        rstd = 1'b0;
        // Hammer r5 with writes for the whole sweep; none may land.
        wa[AW-1:0] = 5'd5; wr[DW-1:0] = 32'hCAFEF00D; wren = 2'b10;
        ra = {5'd9, 5'd5};
        cyc = 0; err = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (rr !== '0) err++;
            step();
            cyc++;
        end
        wren = 2'b11;
        #1;
        n_cmp++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL rst_mid_len: got %0d cycles, required 32", cyc);
        end
        n_cmp++;
        if (err != 0) begin
            n_fail++;
            $display("FAIL busy_rr_zero: %0d cycles nonzero rr, required 0", err);
        end
        n_cmp++;
        if (rr !== '0 || nb_rr !== '0) begin
            n_fail++;
            $display("FAIL busy_write_ignored: rr=%h nb_rr=%h, required 0", rr, nb_rr);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bypass();
        test_zero_reg();
        test_dual_write();
        test_clr_restart();
        test_busy_write_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_reg_file_mp

`default_nettype wire
